// File: rtl/seq_det_param_if.sv
// Serial-input bus for the parametrised sequence detector: sample/control inputs
// plus the registered match pulse, match counter and pattern view.
interface seq_det_param_if #(
    parameter int unsigned N     = 7,
    parameter int unsigned CNT_W = 8
) ();
    logic             ip;
    logic             en;
    logic             overlap;
    logic             pat_ld;
    logic [N-1:0]     pat_in;
    logic             cnt_clr;
    logic             op;
    logic [CNT_W-1:0] match_cnt;
    logic [N-1:0]     pat;

    modport master (
        output ip, en, overlap, pat_ld, pat_in, cnt_clr,
        input  op, match_cnt, pat
    );

    modport slave (
        input  ip, en, overlap, pat_ld, pat_in, cnt_clr,
        output op, match_cnt, pat
    );
endinterface

// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector with a runtime-loadable pattern,
// per-cycle overlap selection and a saturating match counter.
module seq_det_param #(
    parameter int unsigned    N       = 7,
    parameter logic [N-1:0]   PATTERN = N'(7'b1010011),
    parameter int unsigned    CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_det_param_if.slave bus
);
    localparam int unsigned HIST_W   = N - 1;
    localparam int unsigned FILL_W   = $clog2(N);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [N-1:0]      pat_q,  pat_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              op_q,   op_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            op_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
        end
    end

    // fill gates the compare so cleared history can never produce a false match
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        op_d   = 1'b0;
        cnt_d  = cnt_q;
        hit    = bus.en & ~bus.pat_ld & (fill_q == FILL_MAX) &
                 ({hist_q, bus.ip} == pat_q);

        if (bus.pat_ld) begin
            pat_d  = bus.pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d = HIST_W'({hist_q, bus.ip});
            if (hit) begin
                op_d = 1'b1;
                if (!bus.overlap) fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        // counter tracks the op register being loaded, so it moves on the same edge
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (op_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bus.op        = op_q;
    assign bus.match_cnt = cnt_q;
    assign bus.pat       = pat_q;
endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed scenarios plus randomized traffic against a
// queue-based reference model; a CNT_W=2 twin shares stimulus for saturation.
module tb_seq_det_param;
    localparam int unsigned N = 7;
    localparam logic [6:0] DEF_PAT = 7'b1010011;

    logic clk, rst;
    logic ip, en, ov, ld, clr;
    logic [6:0] pin;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit         mq[$];
    logic [6:0] m_pat;
    logic       m_op;
    int         m_c8, m_c2;

    seq_det_param_if #(.N(7), .CNT_W(8)) bus8 ();
    seq_det_param_if #(.N(7), .CNT_W(2)) bus2 ();

    assign bus8.ip = ip;  assign bus8.en = en;  assign bus8.overlap = ov;
    assign bus8.pat_ld = ld;  assign bus8.pat_in = pin;  assign bus8.cnt_clr = clr;
    assign bus2.ip = ip;  assign bus2.en = en;  assign bus2.overlap = ov;
    assign bus2.pat_ld = ld;  assign bus2.pat_in = pin;  assign bus2.cnt_clr = clr;

    seq_det_param #(.N(7), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus8));
    seq_det_param #(.N(7), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        mq.delete();
        m_pat = DEF_PAT;
        m_op  = 1'b0;
        m_c8  = 0;
        m_c2  = 0;
    endfunction

    // last N valid bits, oldest first, compared against the pattern MSB-first
    function automatic bit model_match();
        if (mq.size() != N) return 1'b0;
        for (int i = 0; i < N; i++)
            if (mq[i] != m_pat[N-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step(input logic b_ip, b_en, b_ov, b_ld,
                                       input logic [6:0] b_pin, input logic b_clr);
        m_op = 1'b0;
        if (b_ld) begin
            m_pat = b_pin;
            mq.delete();
        end else if (b_en) begin
            mq.push_back(b_ip);
            if (mq.size() > N) void'(mq.pop_front());
            m_op = model_match();
            if (m_op && !b_ov) mq.delete();
        end
        if (b_clr) begin
            m_c8 = 0;
            m_c2 = 0;
        end else if (m_op) begin
            if (m_c8 < 255) m_c8++;
            if (m_c2 < 3)   m_c2++;
        end
    endfunction

    task automatic step(input logic b_ip, b_en, b_ov, b_ld,
                        input logic [6:0] b_pin, input logic b_clr);
        @(negedge clk);
        ip = b_ip; en = b_en; ov = b_ov; ld = b_ld; pin = b_pin; clr = b_clr;
        model_step(b_ip, b_en, b_ov, b_ld, b_pin, b_clr);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; ld = 1'b0; clr = 1'b0; ip = 1'b0;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ip = 1'b0; en = 1'b0; ov = 1'b1; ld = 1'b0; pin = '0; clr = 1'b0;
        model_reset();
        #12;
        n_vec++; if (bus8.op !== 1'b0) begin n_err++; $display("FAIL reset_op: got %b want 0", bus8.op); end
        n_vec++; if (bus8.match_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus8.match_cnt); end
        n_vec++; if (bus8.pat !== DEF_PAT) begin n_err++; $display("FAIL reset_pat: got %b want %b", bus8.pat, DEF_PAT); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_default();
        logic [6:0] s;
        s = DEF_PAT;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            step(s[6-i], 1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
            n_vec++;
            if (bus8.op !== 1'(i == 6)) begin n_err++; $display("FAIL default_op[%0d]: got %b want %b", i, bus8.op, (i == 6)); end
        end
        n_vec++; if (bus8.match_cnt !== 8'd1) begin n_err++; $display("FAIL default_cnt: got %0d want 1", bus8.match_cnt); end
    endtask

    task automatic test_overlap();
        logic [12:0] s;
        bit exp;
        s = 13'b1010011010011;
        for (int o = 1; o >= 0; o--) begin
            apply_reset();
            for (int i = 0; i < 13; i++) begin
                step(s[12-i], 1'b1, 1'(o), 1'b0, 7'd0, 1'b0);
                exp = (i == 6) || (o == 1 && i == 12);
                n_vec++;
                if (bus8.op !== exp) begin n_err++; $display("FAIL overlap%0d_op[%0d]: got %b want %b", o, i, bus8.op, exp); end
            end
            n_vec++;
            if (bus8.match_cnt !== 8'((o == 1) ? 2 : 1)) begin
                n_err++; $display("FAIL overlap%0d_cnt: got %0d want %0d", o, bus8.match_cnt, (o == 1) ? 2 : 1);
            end
        end
    endtask

    task automatic test_zero_pattern();
        bit exp;
        for (int o = 1; o >= 0; o--) begin
            apply_reset();
            step(1'b1, 1'b1, 1'(o), 1'b1, 7'd0, 1'b0);
            n_vec++; if (bus8.pat !== 7'd0) begin n_err++; $display("FAIL zero%0d_pat: got %b want 0", o, bus8.pat); end
            n_vec++; if (bus8.op !== 1'b0) begin n_err++; $display("FAIL zero%0d_ldop: got %b want 0", o, bus8.op); end
            for (int i = 0; i < 21; i++) begin
                step(1'b0, 1'b1, 1'(o), 1'b0, 7'd0, 1'b0);
                exp = (o == 1) ? (i >= 6) : ((i % 7) == 6);
                n_vec++;
                if (bus8.op !== exp) begin n_err++; $display("FAIL zero%0d_op[%0d]: got %b want %b", o, i, bus8.op, exp); end
            end
        end
    endtask

    task automatic test_en_gaps();
        logic [6:0] s;
        s = DEF_PAT;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            step(s[6-i], 1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
            n_vec++;
            if (bus8.op !== 1'(i == 6)) begin n_err++; $display("FAIL gap_op[%0d]: got %b want %b", i, bus8.op, (i == 6)); end
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 7'd0, 1'b0);
            n_vec++;
            if (bus8.op !== 1'b0) begin n_err++; $display("FAIL gap_idle_op[%0d]: got %b want 0", i, bus8.op); end
        end
        n_vec++; if (bus8.match_cnt !== 8'd1) begin n_err++; $display("FAIL gap_cnt: got %0d want 1", bus8.match_cnt); end
    endtask

    task automatic test_saturate();
        apply_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
            n_vec++;
            if (bus2.match_cnt !== 2'((k + 1 > 3) ? 3 : k + 1)) begin
                n_err++; $display("FAIL sat_cnt2[%0d]: got %0d want %0d", k, bus2.match_cnt, (k + 1 > 3) ? 3 : k + 1);
            end
            n_vec++;
            if (bus8.match_cnt !== 8'(k + 1)) begin n_err++; $display("FAIL sat_cnt8[%0d]: got %0d want %0d", k, bus8.match_cnt, k + 1); end
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1);
        n_vec++; if (bus8.op !== 1'b1) begin n_err++; $display("FAIL clr_op: got %b want 1", bus8.op); end
        n_vec++; if (bus8.match_cnt !== 8'd0) begin n_err++; $display("FAIL clr_cnt8: got %0d want 0", bus8.match_cnt); end
        n_vec++; if (bus2.match_cnt !== 2'd0) begin n_err++; $display("FAIL clr_cnt2: got %0d want 0", bus2.match_cnt); end
        step(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
        n_vec++; if (bus8.match_cnt !== 8'd1) begin n_err++; $display("FAIL post_clr_cnt: got %0d want 1", bus8.match_cnt); end
    endtask

    task automatic test_rst_mid();
        logic [6:0] s;
        s = DEF_PAT;
        apply_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 7'h55, 1'b0);
        for (int i = 0; i < 5; i++) step(s[6-i], 1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1; ld = 1'b1; en = 1'b1;
        model_reset();
        #1;
        n_vec++; if (bus8.pat !== DEF_PAT) begin n_err++; $display("FAIL rstmid_pat: got %b want %b", bus8.pat, DEF_PAT); end
        n_vec++; if (bus8.op !== 1'b0) begin n_err++; $display("FAIL rstmid_op: got %b want 0", bus8.op); end
        #1;
        rst = 1'b0; ld = 1'b0; en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(s[6-i], 1'b1, 1'b1, 1'b0, 7'd0, 1'b0);
            n_vec++;
            if (bus8.op !== 1'(i == 6)) begin n_err++; $display("FAIL rstmid_op[%0d]: got %b want %b", i, bus8.op, (i == 6)); end
        end
        n_vec++; if (bus8.pat !== DEF_PAT) begin n_err++; $display("FAIL rstmid_pat_end: got %b want %b", bus8.pat, DEF_PAT); end
    endtask

    task automatic test_random();
        logic r_ip, r_en, r_ov, r_ld, r_clr;
        logic [6:0] r_pin;
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            r_ld  = 1'(($urandom % 40) == 0);
            r_pin = ($urandom % 2 == 0) ? 7'h7F : 7'($urandom);
            r_ip  = 1'(($urandom % 4) != 0);
            r_en  = 1'(($urandom % 8) != 0);
            r_ov  = 1'($urandom % 2);
            r_clr = 1'(($urandom % 30) == 0);
            step(r_ip, r_en, r_ov, r_ld, r_pin, r_clr);
            n_vec++; if (bus8.op !== m_op) begin n_err++; $display("FAIL rand_op[%0d]: got %b want %b", i, bus8.op, m_op); end
            n_vec++; if (bus8.match_cnt !== 8'(m_c8)) begin n_err++; $display("FAIL rand_cnt8[%0d]: got %0d want %0d", i, bus8.match_cnt, m_c8); end
            n_vec++; if (bus2.match_cnt !== 2'(m_c2)) begin n_err++; $display("FAIL rand_cnt2[%0d]: got %0d want %0d", i, bus2.match_cnt, m_c2); end
            n_vec++; if (bus8.pat !== m_pat) begin n_err++; $display("FAIL rand_pat[%0d]: got %b want %b", i, bus8.pat, m_pat); end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_overlap();
        test_zero_pattern();
        test_en_gaps();
        test_saturate();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial sequence detector. Samples one bit per enabled clock, compares the most recent N bits against a pattern register and pulses `op` on a match. The pattern register is runtime-loadable and holds the PATTERN default after reset. Overlapping or non-overlapping detection is selectable per cycle, and a saturating match counter is provided. It sits directly on the serial input path, alongside the fixed 7-bit detectors, and replaces them where the pattern or the mode must change.

## Interface
- N, 7, pattern length in bits; legal range 2..32
- PATTERN, 7'b1010011, reset value of the pattern register; bit N-1 is received first (oldest), bit 0 last (newest)
- CNT_W, 8, width of match counter
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- ip  input  1  serial data bit, sampled on rising clk when en=1
- en  input  1  sample enable; en=0 means no bit consumed this cycle
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- pat_ld  input  1  load pat_in into the pattern register
- pat_in  input  N  new pattern, same bit ordering as PATTERN
- cnt_clr  input  1  synchronous clear of match_cnt
- op  output  1  registered one-cycle match pulse
- match_cnt  output  CNT_W  number of matches since reset/clear, saturating
- pat  output  N  current pattern register contents

## Operation
- State:
  - pattern register pat[N-1:0]
  - history hist[N-2:0], where hist[0] is the most recently sampled bit
  - fill counter fill, width clog2(N); counts valid history bits, 0..N-1, saturating at N-1
  - op register
  - match_cnt
- Combinational match: hit = en & ~pat_ld & (fill == N-1) & ({hist[N-2:0], ip} == pat).
- On each rising edge, in priority order:
  - pat_ld=1: pat <= pat_in; hist <= 0; fill <= 0; op <= 0. ip and en are ignored this cycle.
  - en=1, hit=1, overlap=1: hist <= {hist[N-3:0], ip}; fill stays N-1; op <= 1.
  - en=1, hit=1, overlap=0: hist shifts as above; fill <= 0, so all N-1 prior bits are invalid and the next match needs N fresh bits; op <= 1.
  - en=1, hit=0: hist shifts; fill <= min(fill+1, N-1); op <= 0.
  - en=0: hist, fill and pat hold; op <= 0.
- The fill counter guarantees no false match from reset/cleared history. Example: pattern all-zeros cannot fire until N bits have been sampled.
- overlap is evaluated in the cycle of the match only. Changing it mid-stream affects no stored state.
- match_cnt:
  - cnt_clr=1: match_cnt <= 0. Clear wins over a simultaneous increment.
  - else, when op is registered 1 (same edge as op rising): match_cnt <= match_cnt+1, saturating at 2^CNT_W-1.
- pat output is a direct view of the pattern register.

## Timing
- Reset (async, immediate): pat=PATTERN, hist=0, fill=0, op=0, match_cnt=0.
- Latency: op is high in the cycle following the edge that samples the final pattern bit. Zero added cycles beyond the register.
- op pulse width is exactly 1 cycle per match. Back-to-back pulses are possible only with overlap=1 and a self-overlapping pattern (e.g. all-ones).
- match_cnt updates on the same edge op rises, so it is visible in the op=1 cycle.
- pat_ld takes effect at the next edge. The first bit sampled under the new pattern is the one at the edge after the load.
- rst asserted mid-stream clears everything regardless of pat_ld/en; a loaded pattern is lost and reverts to PATTERN.
- Gaps with en=0 are transparent: a pattern split across disabled cycles still matches.

## Test plan
- Default pattern, overlap=1, en=1, ip stream 1,0,1,0,0,1,1 after reset -> op=1 only in the cycle after the 7th bit; match_cnt=1.
- Stream 1,0,1,0,0,1,1,0,1,0,0,1,1 with overlap=1 -> op pulses after bits 7 and 13, match_cnt=2. Same stream with overlap=0 -> op pulses after bit 7 only, match_cnt=1.
- pat_ld with pat_in=0 then ip=0 continuously -> no op for the first 6 sampled bits; op after the 7th. With overlap=1, op stays high every following cycle; with overlap=0, op pulses every 7th cycle.
- Default pattern with en toggled low between each bit -> single op pulse after the 7th enabled bit; op=0 during all en=0 cycles.
- CNT_W=2 with 5 matches -> match_cnt saturates at 3. cnt_clr asserted on a match edge -> match_cnt=0 and op=1.
- rst pulsed after the 5th of 7 pattern bits, then the full 7 bits sent -> no op before the re-sent 7th bit; op once after it; pat=PATTERN.
